// File: rtl/captcha_square_sequencer.sv
// Random 3x3-grid CAPTCHA: generates a square pattern, plays it to the mapper,
// then grades user clicks. Optional replay port: `define CAPTCHA_REPLAY_EN.
module captcha_square_sequencer #(
  parameter int         SEQ_LEN     = 4,
  parameter int         ON_TICKS    = 30,
  parameter int         GAP_TICKS   = 10,
  parameter logic [4:0] IDLE_SQUARE = 5'd9,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       user_valid,
  input  logic [4:0] user_square,
`ifdef CAPTCHA_REPLAY_EN
  input  logic       replay,
`endif
  output logic [4:0] square,
  output logic       square_valid,
  output logic       busy,
  output logic       awaiting_input,
  output logic       pass,
  output logic       fail,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW, S_GAP, S_INPUT, S_RESULT
  } state_e;

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);

  state_e                    state_q, state_d;
  logic [7:0]                lfsr_q, lfsr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [SEQ_LEN-1:0][3:0]   seq_q, seq_d;
  logic                      pass_q, pass_d, fail_q, fail_d, done_q, done_d;
  logic [3:0]                cand;
  logic                      cand_ok, user_hit, replay_w;

`ifdef CAPTCHA_REPLAY_EN
  assign replay_w = replay;
`else
  assign replay_w = 1'b0;
`endif

  // Free-running so the pattern depends on when start arrives.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign cand     = lfsr_q[3:0];
  assign cand_ok  = (cand < 4'd9) &&
                    ((idx_q == '0) || (cand != seq_q[idx_q - 1'b1]));
  assign user_hit = (user_square < 5'd9) && (user_square == {1'b0, seq_q[idx_q]});

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GEN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_GEN: begin
        if (cand_ok) begin
          seq_d[idx_q] = cand;
          if (idx_q == LAST_IDX) begin
            state_d = S_SHOW;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = S_INPUT;
              idx_d   = '0;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_INPUT: begin
        if (replay_w) begin
          state_d = S_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else if (user_valid) begin
          if (!user_hit) begin
            state_d = S_RESULT;
            fail_d  = 1'b1;
            done_d  = 1'b1;
            idx_d   = '0;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_RESULT;
            pass_d  = 1'b1;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (replay_w) begin
          state_d = S_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else if (start) begin
          state_d = S_GEN;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      cnt_q   <= '0;
      seq_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  // Decoded from state so an async reset reaches the outputs without a clock.
  assign square         = (state_q == S_SHOW) ? {1'b0, seq_q[idx_q]} : IDLE_SQUARE;
  assign square_valid   = (state_q == S_SHOW);
  assign busy           = (state_q == S_GEN) || (state_q == S_SHOW) || (state_q == S_GAP);
  assign awaiting_input = (state_q == S_INPUT);
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign done           = done_q;

endmodule

// File: tb/tb_captcha_square_sequencer.sv
// Directed bench for captcha_square_sequencer (SEQ_LEN=4, ON=3, GAP=2).
// Expected patterns come from an independent LFSR reference.
module tb_captcha_square_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, tick, start, user_valid;
  logic [4:0] user_square;
`ifdef CAPTCHA_REPLAY_EN
  logic       replay;
`endif
  logic [4:0] square;
  logic       square_valid, busy, awaiting_input, pass, fail, done;
  logic [10:0] obs;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  m_lfsr;
  logic [15:0] exp_a, cap_a, exp_b, cap_b, exp_c;
`ifdef CAPTCHA_REPLAY_EN
  logic [15:0] exp_d, cap_d;
`endif

  captcha_square_sequencer #(
    .SEQ_LEN(4), .ON_TICKS(3), .GAP_TICKS(2), .IDLE_SQUARE(5'd9), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .user_valid(user_valid), .user_square(user_square),
`ifdef CAPTCHA_REPLAY_EN
    .replay(replay),
`endif
    .square(square), .square_valid(square_valid), .busy(busy),
    .awaiting_input(awaiting_input), .pass(pass), .fail(fail), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {square, square_valid, busy, awaiting_input, pass, fail, done};

  function automatic logic [7:0] step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference LFSR, stepped every edge like the design's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= step(m_lfsr);
  end

  function automatic logic [15:0] predict(input logic [7:0] l0);
    logic [7:0]  l;
    logic [3:0]  c, prev;
    logic [15:0] p;
    int n;
    l = l0; n = 0; prev = '0; p = '0;
    for (int k = 0; k < 1000 && n < 4; k++) begin
      c = l[3:0];
      if (c < 4'd9 && (n == 0 || c != prev)) begin
        p[n*4 +: 4] = c;
        prev = c;
        n++;
      end
      l = step(l);
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic give(input logic [4:0] s);
    user_valid  = 1'b1;
    user_square = s;
    @(negedge clk);
    user_valid  = 1'b0;
  endtask

  // Waits for the first lit square, then checks the whole show/gap sequence.
  task automatic play_check(input logic [15:0] expv, input int min_wait,
                            output logic [15:0] capv);
    int w;
    w = 0;
    capv = '0;
    while (!square_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("first_show_bound", 16'(w < 200), 16'd1);
    chk("gen_latency", 16'(w >= min_wait), 16'd1);
    for (int i = 0; i < 4; i++) begin
      capv[i*4 +: 4] = square[3:0];
      chk("square_range", 16'(square < 5'd9), 16'd1);
      if (i > 0) chk("square_consec_differ", 16'(square[3:0] != capv[(i-1)*4 +: 4]), 16'd1);
      for (int c = 0; c < 3; c++) begin
        chk("show", {5'b0, obs}, {5'b0, 1'b0, expv[i*4 +: 4], 6'b110000});
        @(negedge clk);
      end
      if (i < 3) begin
        for (int c = 0; c < 2; c++) begin
          chk("gap", {5'b0, obs}, {5'b0, 5'd9, 6'b010000});
          @(negedge clk);
        end
      end
    end
    chk("await_input", {5'b0, obs}, {5'b0, 5'd9, 6'b001000});
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; start = 1'b0; user_valid = 1'b0; user_square = '0;
`ifdef CAPTCHA_REPLAY_EN
    replay = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_outputs", {5'b0, obs}, {5'b0, 5'd9, 6'b000000});
    rst_n = 1'b1;

    // Idle: nothing moves without start.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle", {5'b0, obs}, {5'b0, 5'd9, 6'b000000});
    end

    // First pattern.
    pulse_start();
    chk("gen_busy", {5'b0, obs}, {5'b0, 5'd9, 6'b010000});
    exp_a = predict(m_lfsr);
    play_check(exp_a, 4, cap_a);

    // Correct answer.
    for (int i = 0; i < 3; i++) begin
      give({1'b0, cap_a[i*4 +: 4]});
      chk("input_progress", {5'b0, obs}, {5'b0, 5'd9, 6'b001000});
    end
    give({1'b0, cap_a[12 +: 4]});
    chk("pass_done", {5'b0, obs}, {5'b0, 5'd9, 6'b000101});
    @(negedge clk);
    chk("pass_held_done_drop", {5'b0, obs}, {5'b0, 5'd9, 6'b000100});

    // New pattern from RESULT clears pass.
    pulse_start();
    chk("restart_clears_pass", {5'b0, obs}, {5'b0, 5'd9, 6'b010000});
    exp_b = predict(m_lfsr);
    play_check(exp_b, 4, cap_b);

    // Right first square, then an out-of-grid click.
    give({1'b0, cap_b[3:0]});
    chk("first_ok", {5'b0, obs}, {5'b0, 5'd9, 6'b001000});
    give(5'd9);
    chk("fail_on_9", {5'b0, obs}, {5'b0, 5'd9, 6'b000011});
    give({1'b0, cap_b[7:4]});
    chk("fail_held_1", {5'b0, obs}, {5'b0, 5'd9, 6'b000010});
    give({1'b0, cap_b[11:8]});
    chk("fail_held_2", {5'b0, obs}, {5'b0, 5'd9, 6'b000010});

    // Stalled SHOW with ignored start pulses, then reset mid-GAP.
    pulse_start();
    exp_c = predict(m_lfsr);
    begin
      int w;
      w = 0;
      while (!square_valid && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("stall_first_show_bound", 16'(w < 200), 16'd1);
    end
    tick = 1'b0;
    for (int k = 0; k < 50; k++) begin
      start = (k == 10 || k == 30);
      @(negedge clk);
      chk("stall_hold", {5'b0, obs}, {5'b0, 1'b0, exp_c[3:0], 6'b110000});
    end
    start = 1'b0;
    tick  = 1'b1;
    @(negedge clk);
    chk("resume_show_1", {5'b0, obs}, {5'b0, 1'b0, exp_c[3:0], 6'b110000});
    @(negedge clk);
    chk("resume_show_2", {5'b0, obs}, {5'b0, 1'b0, exp_c[3:0], 6'b110000});
    @(negedge clk);
    chk("resume_gap", {5'b0, obs}, {5'b0, 5'd9, 6'b010000});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {5'b0, obs}, {5'b0, 5'd9, 6'b000000});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {5'b0, obs}, {5'b0, 5'd9, 6'b000000});

`ifdef CAPTCHA_REPLAY_EN
    // Fail, then replay the unchanged pattern and answer it.
    pulse_start();
    exp_d = predict(m_lfsr);
    play_check(exp_d, 4, cap_d);
    give((cap_d[3:0] == 4'd8) ? 5'd0 : {1'b0, cap_d[3:0] + 4'd1});
    chk("replay_pre_fail", {5'b0, obs}, {5'b0, 5'd9, 6'b000011});
    @(negedge clk);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    chk("replay_show", {5'b0, obs}, {5'b0, 1'b0, exp_d[3:0], 6'b110000});
    play_check(exp_d, 0, cap_d);
    for (int i = 0; i < 4; i++) give({1'b0, exp_d[i*4 +: 4]});
    chk("replay_pass", {5'b0, obs}, {5'b0, 5'd9, 6'b000101});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
